branch_pc_controller: RTL and testbench

Sequences the program counter of the single-cycle RISC-V core: holds the PC register, computes B-type, JAL and JALR targets, resolves branch conditions from comparator flags, and gates PC advance on a run/stall handshake with the UART loader and memory-mapped UART. It sits between instruction fetch and the ALU comparator and replaces ad-hoc next-PC logic with one owned, registered controller.

---
 rtl/branch_pc_controller_pkg.sv | 48 ++++
 rtl/branch_pc_controller_if.sv | 27 ++
 rtl/branch_pc_controller_target_gen.sv | 30 +++
 rtl/branch_pc_controller.sv | 160 ++++++++++++++++
 tb/tb_branch_pc_controller.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/branch_pc_controller_pkg.sv
// Shared constants for the branch/PC controller: opcodes, funct3 codes, state encoding.
// The misaligned-target trap is enabled by defining PC_MISALIGN_TRAP_EN.
package branch_pc_pkg;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // instr[31:7] patterns that identify ECALL and EBREAK
  localparam logic [24:0] SYS_ECALL  = 25'h0000000;
  localparam logic [24:0] SYS_EBREAK = 25'h0002000;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BOOT = 2'd1,
    ST_RUN  = 2'd2,
    ST_HALT = 2'd3
  } pc_state_e;

  function automatic logic branch_taken(input logic [2:0] funct3,
                                        input logic eq,
                                        input logic lt,
                                        input logic ltu);
    logic taken;
    taken = 1'b0;
    case (funct3)
      F3_BEQ:  taken = eq;
      F3_BNE:  taken = !eq;
      F3_BLT:  taken = lt;
      F3_BGE:  taken = !lt;
      F3_BLTU: taken = ltu;
      F3_BGEU: taken = !ltu;
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/branch_pc_controller_if.sv
// Fetch/comparator side bundle of the PC controller. master = core side, slave = controller.
// Handshake: pc advances only on a RUN cycle with stall=0; inputs stay stable while stall=1.
interface branch_pc_controller_if;
  logic        run;
  logic        stall;
  logic [31:0] instr;
  logic [31:0] rs1_data;
  logic        cmp_eq;
  logic        cmp_lt;
  logic        cmp_ltu;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        redirect;
  logic        halted;
  logic [1:0]  state;
  logic        trap;

  modport master (
    output run, stall, instr, rs1_data, cmp_eq, cmp_lt, cmp_ltu,
    input  pc, pc_plus4, redirect, halted, state, trap
  );

  modport slave (
    input  run, stall, instr, rs1_data, cmp_eq, cmp_lt, cmp_ltu,
    output pc, pc_plus4, redirect, halted, state, trap
  );
endinterface

// File: rtl/branch_pc_controller_target_gen.sv
// Combinational B-type, JAL and JALR target generation from the instruction immediates.
// Only instr[31:7] is needed; the opcode is decoded by the controller.
module branch_target_gen (
  input  logic [31:0] pc,
  input  logic [24:0] instr_hi,
  input  logic [31:0] rs1_data,
  output logic [31:0] br_target,
  output logic [31:0] jal_target,
  output logic [31:0] jalr_target
);

  logic [31:0] instr_full;
  logic [31:0] imm_b;
  logic [31:0] imm_j;
  logic [31:0] imm_i;

  // Re-align so bit indices below match the ISA manual
  assign instr_full = {instr_hi, 7'b0};

  assign imm_b = {{19{instr_full[31]}}, instr_full[31], instr_full[7],
                  instr_full[30:25], instr_full[11:8], 1'b0};
  assign imm_j = {{11{instr_full[31]}}, instr_full[31], instr_full[19:12],
                  instr_full[20], instr_full[30:21], 1'b0};
  assign imm_i = {{20{instr_full[31]}}, instr_full[31:20]};

  assign br_target   = pc + imm_b;
  assign jal_target  = pc + imm_j;
  assign jalr_target = (rs1_data + imm_i) & ~32'h1;

endmodule

// File: rtl/branch_pc_controller.sv
// Registered program-counter sequencer: IDLE/BOOT/RUN/HALT FSM, branch resolution, stall gating.
// Define PC_MISALIGN_TRAP_EN to halt with trap=1 on a taken target whose bit 1 is set.
module branch_pc_controller
  import branch_pc_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int          BOOT_WAIT = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  branch_pc_controller_if.slave bus
);

  localparam logic [3:0] BOOT_LAST = 4'(BOOT_WAIT - 1);

  pc_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        redirect_q, redirect_d;
  logic [3:0]  boot_cnt_q, boot_cnt_d;

  logic [31:0] pc_plus4;
  logic [31:0] br_target, jal_target, jalr_target;
  logic [31:0] target;
  logic        is_jump;
  logic        is_halt;
  logic [6:0]  opcode;

  assign pc_plus4 = pc_q + 32'd4;
  assign opcode   = bus.instr[6:0];

  branch_target_gen u_target_gen (
    .pc          (pc_q),
    .instr_hi    (bus.instr[31:7]),
    .rs1_data    (bus.rs1_data),
    .br_target   (br_target),
    .jal_target  (jal_target),
    .jalr_target (jalr_target)
  );

  // Decode: which non-sequential target (if any) this instruction selects
  always_comb begin
    is_jump = 1'b0;
    is_halt = 1'b0;
    target  = pc_plus4;
    case (opcode)
      OP_BRANCH: begin
        if (branch_taken(bus.instr[14:12], bus.cmp_eq, bus.cmp_lt, bus.cmp_ltu)) begin
          is_jump = 1'b1;
          target  = br_target;
        end
      end
      OP_JAL: begin
        is_jump = 1'b1;
        target  = jal_target;
      end
      OP_JALR: begin
        is_jump = 1'b1;
        target  = jalr_target;
      end
      OP_SYSTEM: begin
        is_halt = (bus.instr[31:7] == SYS_ECALL) || (bus.instr[31:7] == SYS_EBREAK);
      end
      default: begin
        is_jump = 1'b0;
      end
    endcase
  end

`ifdef PC_MISALIGN_TRAP_EN
  logic trap_q, trap_d;
`endif

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    redirect_d = 1'b0;
    boot_cnt_d = boot_cnt_q;
`ifdef PC_MISALIGN_TRAP_EN
    trap_d     = trap_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.run) begin
          state_d    = ST_BOOT;
          boot_cnt_d = 4'd0;
        end
      end
      ST_BOOT: begin
        if (boot_cnt_q == BOOT_LAST) begin
          state_d = ST_RUN;
        end else begin
          boot_cnt_d = boot_cnt_q + 4'd1;
        end
      end
      ST_RUN: begin
        // A stalled cycle freezes everything, including decoding of a halt
        if (!bus.stall) begin
          if (is_halt) begin
            state_d = ST_HALT;
          end else if (is_jump) begin
`ifdef PC_MISALIGN_TRAP_EN
            if (target[1]) begin
              state_d = ST_HALT;
              trap_d  = 1'b1;
            end else begin
              pc_d       = target;
              redirect_d = 1'b1;
            end
`else
            pc_d       = target & ~32'h2;
            redirect_d = 1'b1;
`endif
          end else begin
            pc_d = pc_plus4;
          end
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      redirect_q <= 1'b0;
      boot_cnt_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      redirect_q <= redirect_d;
      boot_cnt_q <= boot_cnt_d;
    end
  end

`ifdef PC_MISALIGN_TRAP_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      trap_q <= 1'b0;
    end else begin
      trap_q <= trap_d;
    end
  end
  assign bus.trap = trap_q;
`else
  assign bus.trap = 1'b0;
`endif

  assign bus.pc       = pc_q;
  assign bus.pc_plus4 = pc_plus4;
  assign bus.redirect = redirect_q;
  assign bus.halted   = (state_q == ST_HALT);
  assign bus.state    = state_q;

endmodule

// File: tb/tb_branch_pc_controller.sv
// Bench for branch_pc_controller: directed plan steps followed by randomized traffic,
// all checked against an arithmetic reference model of the PC sequencing rules.
module tb_branch_pc_controller;

  localparam int          BW   = 4;
  localparam logic [31:0] RPC  = 32'h0000_0000;
  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam int M_IDLE = 0, M_BOOT = 1, M_RUN = 2, M_HALT = 3;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  branch_pc_controller_if bus();

  branch_pc_controller #(.RESET_PC(RPC), .BOOT_WAIT(BW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state
  int          m_state;
  logic [31:0] m_pc;
  logic        m_redirect;
  logic        m_trap;
  int          m_boot_left;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int off_b(input logic [31:0] i);
    return (i[31] ? -4096 : 0) + int'(i[7]) * 2048 + int'(i[30:25]) * 32 + int'(i[11:8]) * 2;
  endfunction

  function automatic int off_j(input logic [31:0] i);
    return (i[31] ? -1048576 : 0) + int'(i[19:12]) * 4096 + int'(i[20]) * 2048
           + int'(i[30:21]) * 2;
  endfunction

  function automatic int off_i(input logic [31:0] i);
    return (i[31] ? -2048 : 0) + int'(i[30:20]);
  endfunction

  function automatic logic [31:0] enc_b(input logic [2:0] f3, input int off);
    logic [12:0] o;
    o = 13'(off);
    return {o[12], o[10:5], 5'd0, 5'd0, f3, o[4:1], o[11], 7'h63};
  endfunction

  // Advance the model by one clock edge using the inputs currently applied
  task automatic model_step();
    logic [31:0] tgt;
    logic        jump, halt, taken;
    if (reset) begin
      m_state = M_IDLE; m_pc = RPC; m_redirect = 1'b0; m_trap = 1'b0; m_boot_left = 0;
      return;
    end
    m_redirect = 1'b0;
    case (m_state)
      M_IDLE: if (bus.run) begin m_state = M_BOOT; m_boot_left = BW; end
      M_BOOT: begin
        m_boot_left--;
        if (m_boot_left == 0) m_state = M_RUN;
      end
      M_RUN: if (!bus.stall) begin
        jump = 1'b0; halt = 1'b0; tgt = m_pc + 32'd4;
        case (bus.instr[6:0])
          7'h63: begin
            case (bus.instr[14:12])
              3'd0: taken = bus.cmp_eq;
              3'd1: taken = !bus.cmp_eq;
              3'd4: taken = bus.cmp_lt;
              3'd5: taken = !bus.cmp_lt;
              3'd6: taken = bus.cmp_ltu;
              3'd7: taken = !bus.cmp_ltu;
              default: taken = 1'b0;
            endcase
            if (taken) begin jump = 1'b1; tgt = m_pc + 32'(off_b(bus.instr)); end
          end
          7'h6F: begin jump = 1'b1; tgt = m_pc + 32'(off_j(bus.instr)); end
          7'h67: begin
            jump = 1'b1;
            tgt = bus.rs1_data + 32'(off_i(bus.instr));
            if (tgt[0]) tgt = tgt - 32'd1;
          end
          7'h73: halt = (bus.instr == 32'h0000_0073) || (bus.instr == 32'h0010_0073);
          default: ;
        endcase
        if (halt) m_state = M_HALT;
        else if (jump) begin
`ifdef PC_MISALIGN_TRAP_EN
          if (tgt[1]) begin m_state = M_HALT; m_trap = 1'b1; end
          else begin m_pc = tgt; m_redirect = 1'b1; end
`else
          if (tgt[1]) tgt = tgt - 32'd2;
          m_pc = tgt; m_redirect = 1'b1;
`endif
        end else m_pc = tgt;
      end
      default: ;
    endcase
  endtask

  task automatic check_all();
    check("pc", bus.pc, m_pc);
    check("pc_plus4", bus.pc_plus4, m_pc + 32'd4);
    check("state", 32'(bus.state), 32'(m_state));
    check("redirect", 32'(bus.redirect), 32'(m_redirect));
    check("halted", 32'(bus.halted), 32'(m_state == M_HALT));
    check("trap", 32'(bus.trap), 32'(m_trap));
  endtask

  task automatic tick();
    model_step();
    @(posedge clock);
    #1;
    check_all();
  endtask

  task automatic quiet_inputs();
    bus.run = 1'b0; bus.stall = 1'b0; bus.instr = NOP; bus.rs1_data = 32'd0;
    bus.cmp_eq = 1'b0; bus.cmp_lt = 1'b0; bus.cmp_ltu = 1'b0;
  endtask

  task automatic boot();
    quiet_inputs();
    reset = 1'b1; tick(); tick();
    reset = 1'b0; bus.run = 1'b1; tick();
    bus.run = 1'b0;
    repeat (BW) tick();
  endtask

  task automatic goto_pc(input logic [31:0] addr);
    bus.stall = 1'b0; bus.instr = 32'h0000_0067; bus.rs1_data = addr; tick();
    bus.instr = NOP;
  endtask

  initial begin
    logic [31:0] r;
    int sel;
    quiet_inputs();
    reset = 1'b1;
    m_state = M_IDLE; m_pc = RPC; m_redirect = 1'b0; m_trap = 1'b0; m_boot_left = 0;

    // Reset values and boot sequencing
    tick(); tick();
    check("reset_state", 32'(bus.state), 32'd0);
    check("reset_pc", bus.pc, 32'h0);
    reset = 1'b0; bus.run = 1'b1; tick();
    check("boot_entered", 32'(bus.state), 32'd1);
    bus.run = 1'b0;
    repeat (BW - 1) tick();
    check("still_boot", 32'(bus.state), 32'd1);
    tick();
    check("run_entered", 32'(bus.state), 32'd2);
    check("first_fetch_pc", bus.pc, 32'h0);
    tick(); check("nop_pc4", bus.pc, 32'h4);
    tick(); check("nop_pc8", bus.pc, 32'h8);

    // BEQ -8 taken / not taken
    goto_pc(32'h100);
    bus.instr = 32'hFE00_0CE3; bus.cmp_eq = 1'b1; tick();
    check("beq_taken_pc", bus.pc, 32'h0F8);
    check("beq_taken_redirect", 32'(bus.redirect), 32'd1);
    goto_pc(32'h100);
    bus.instr = 32'hFE00_0CE3; bus.cmp_eq = 1'b0; tick();
    check("beq_not_taken_pc", bus.pc, 32'h104);
    check("beq_not_taken_redirect", 32'(bus.redirect), 32'd0);

    // JAL +0x800, then JALR with odd rs1
    goto_pc(32'h200);
    bus.instr = 32'h0010_006F; tick();
    check("jal_pc", bus.pc, 32'hA00);
    bus.instr = 32'h0000_0067; bus.rs1_data = 32'h1235; tick();
    check("jalr_pc", bus.pc, 32'h1234);

    // Stalled taken BNE, then reset during a stall
    goto_pc(32'h40);
    bus.instr = enc_b(3'b001, 32); bus.cmp_eq = 1'b0; bus.stall = 1'b1;
    repeat (3) begin
      tick();
      check("stall_hold_pc", bus.pc, 32'h40);
    end
    bus.stall = 1'b0; tick();
    check("bne_after_stall", bus.pc, 32'h60);
    bus.stall = 1'b1; tick();
    reset = 1'b1; tick();
    check("reset_in_stall_pc", bus.pc, RPC);
    check("reset_in_stall_state", 32'(bus.state), 32'd0);
    reset = 1'b0;
    boot();

    // Misaligned branch target 0x102
    goto_pc(32'h100);
    bus.instr = enc_b(3'b000, 2); bus.cmp_eq = 1'b1; tick();
`ifdef PC_MISALIGN_TRAP_EN
    check("misalign_trap", 32'(bus.trap), 32'd1);
    check("misalign_pc", bus.pc, 32'h100);
    check("misalign_state", 32'(bus.state), 32'd3);
`else
    check("misalign_trap", 32'(bus.trap), 32'd0);
    check("misalign_pc", bus.pc, 32'h100);
    check("misalign_state", 32'(bus.state), 32'd2);
`endif
    boot();

    // EBREAK halts; run/stall pulses are ignored
    goto_pc(32'h80);
    bus.instr = 32'h0010_0073; tick();
    check("ebreak_halted", 32'(bus.halted), 32'd1);
    check("ebreak_pc", bus.pc, 32'h80);
    for (int i = 0; i < 6; i++) begin
      bus.run = i[0]; bus.stall = i[1]; bus.instr = 32'h0000_006F; tick();
    end
    check("halt_sticky_pc", bus.pc, 32'h80);
    check("halt_sticky_state", 32'(bus.state), 32'd3);
    boot();

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      reset = (m_state == M_HALT && $urandom_range(0, 3) == 0) || ($urandom_range(0, 199) == 0);
      bus.run = ($urandom_range(0, 1) == 1);
      bus.stall = ($urandom_range(0, 3) == 0);
      bus.cmp_eq = 1'($urandom_range(0, 1));
      bus.cmp_lt = 1'($urandom_range(0, 1));
      bus.cmp_ltu = 1'($urandom_range(0, 1));
      bus.rs1_data = $urandom();
      r = $urandom();
      sel = $urandom_range(0, 19);
      if (sel < 6)       bus.instr = {r[31:7], 7'h63};
      else if (sel < 8)  bus.instr = {r[31:7], 7'h6F};
      else if (sel < 10) bus.instr = {r[31:7], 7'h67};
      else if (sel == 10) bus.instr = 32'h0000_0073;
      else if (sel == 11) bus.instr = 32'h0010_0073;
      else if (sel == 12) bus.instr = {r[31:7], 7'h73};
      else               bus.instr = {r[31:7], 7'h13};
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
